apb_controller: RTL



---
 rtl/apb_controller.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_controller.sv
// apb_controller: APB-side transfer sequencer of the AHB-to-APB bridge.
// Turns decoded AHB transfers into APB SETUP/ACCESS phases, one at a time.
// Optional feature macro: APB_PREADY_EN (adds pready, stretches ACCESS phases).
module apb_controller #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SEL_W  = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic [ADDR_W-1:0] haddr,
  input  logic              hwrite,
  input  logic [SEL_W-1:0]  tempselx,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] prdata,
`ifdef APB_PREADY_EN
  input  logic              pready,
`endif
  output logic              pwrite,
  output logic              penable,
  output logic [SEL_W-1:0]  pselx,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hreadyout,
  output logic [DATA_W-1:0] hrdata
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WWAIT   = 3'd1,
    ST_READ    = 3'd2,
    ST_WRITE   = 3'd3,
    ST_RENABLE = 3'd4,
    ST_WENABLE = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic                pwrite_q, pwrite_d;
  logic                penable_q, penable_d;
  logic [SEL_W-1:0]    pselx_q, pselx_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [ADDR_W-1:0]   addr_hold_q, addr_hold_d;
  logic [SEL_W-1:0]    sel_hold_q, sel_hold_d;

  logic                access_done_c;
  logic                sample_c;

`ifdef APB_PREADY_EN
  assign access_done_c = pready;
`else
  assign access_done_c = 1'b1;
`endif

  // A new AHB transfer may be accepted only while the AHB side sees ready.
  assign sample_c = (state_q == ST_IDLE) ||
                    (((state_q == ST_RENABLE) || (state_q == ST_WENABLE)) && access_done_c);

  // State register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // APB output and write-holding registers.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pwrite_q    <= 1'b0;
      penable_q   <= 1'b0;
      pselx_q     <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      addr_hold_q <= '0;
      sel_hold_q  <= '0;
    end else begin
      pwrite_q    <= pwrite_d;
      penable_q   <= penable_d;
      pselx_q     <= pselx_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      addr_hold_q <= addr_hold_d;
      sel_hold_q  <= sel_hold_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (sample_c) begin
          if (valid) begin
            state_d = hwrite ? ST_WWAIT : ST_READ;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_WWAIT: state_d = ST_WRITE;
      ST_READ:  state_d = ST_RENABLE;
      ST_WRITE: state_d = ST_WENABLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the APB bundle; writes wait one cycle for AHB data.
  always_comb begin
    pwrite_d    = pwrite_q;
    penable_d   = penable_q;
    pselx_d     = pselx_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    addr_hold_d = addr_hold_q;
    sel_hold_d  = sel_hold_q;
    if (sample_c) begin
      pselx_d   = '0;
      pwrite_d  = 1'b0;
      penable_d = 1'b0;
      if (valid && !hwrite) begin
        paddr_d = haddr;
        pselx_d = tempselx;
      end
      if (valid && hwrite) begin
        addr_hold_d = haddr;
        sel_hold_d  = tempselx;
      end
    end else begin
      case (state_q)
        ST_WWAIT: begin
          pwdata_d  = hwdata;
          paddr_d   = addr_hold_q;
          pselx_d   = sel_hold_q;
          pwrite_d  = 1'b1;
          penable_d = 1'b0;
        end
        ST_READ, ST_WRITE: begin
          penable_d = 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // AHB-side handshake decoded from the current state.
  always_comb begin
    hreadyout = 1'b0;
    case (state_q)
      ST_IDLE:                 hreadyout = 1'b1;
      ST_RENABLE, ST_WENABLE:  hreadyout = access_done_c;
      default:                 hreadyout = 1'b0;
    endcase
  end

  assign hrdata  = prdata;
  assign pwrite  = pwrite_q;
  assign penable = penable_q;
  assign pselx   = pselx_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule
